// File: rtl/grayscale_controller_pkg.sv
// Shared definitions for the grayscale frame controller: FSM state encoding,
// default image/pixel geometry and a small width helper.
package grayscale_controller_pkg;

  // Frame-level controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } gs_state_e;

  // Default geometry: 640x480 frame of 24-bit RGB pixels
  localparam int unsigned DEF_PIXEL_DEPTH = 24;
  localparam int unsigned DEF_IMG_WIDTH   = 640;
  localparam int unsigned DEF_IMG_HEIGHT  = 480;
  localparam int unsigned DEF_ADDR_WIDTH  = 19;
  localparam int unsigned DEF_GS_LATENCY  = 1;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;

  // Counter width that stays at least 1 bit for degenerate sizes
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? int'($clog2(v)) : 1;
  endfunction

endpackage

// File: rtl/grayscale_controller_gs_out_fifo.sv
// gs_out_fifo: synchronous output buffer for gray pixels.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   push, push_data - write one entry (accepted when not full, or when full
//                     and a pop happens in the same cycle)
//   pop, pop_data   - read/remove head entry (ignored when empty); pop_data
//                     is the current head, forced to zero while empty
//   full, empty     - occupancy flags
//   count           - current occupancy
// No combinational bypass: a push into an empty buffer is visible next cycle.
module gs_out_fifo
  import grayscale_controller_pkg::*;
#(
  parameter int unsigned P_WIDTH = 8,
  parameter int unsigned P_DEPTH = 4,
  localparam int unsigned CNT_W  = $clog2(P_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [P_WIDTH-1:0] push_data,
  input  logic               pop,
  output logic [P_WIDTH-1:0] pop_data,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned PTR_W = clog2_min1(P_DEPTH);

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Circular pointer advance that also works for non-power-of-two depths
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(P_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; stale entries are never exposed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign full     = (count == CNT_W'(P_DEPTH));
  assign empty    = (count == '0);
  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/grayscale_controller.sv
// grayscale_controller: streams one frame of RGB pixels from a source memory
// through an external grayscale unit and writes gray pixels to a sink.
// Ports:
//   I_CLK, I_RESET           - clock, synchronous active-high reset
//   I_START                  - start-frame pulse (honoured only in IDLE)
//   O_BUSY, O_DONE           - frame in progress / one-cycle completion pulse
//   O_RD_EN, O_RD_ADDR       - source read strobe and pixel address
//   I_RD_DATA                - RGB data, valid one cycle after O_RD_EN
//   O_GS_PIXEL, I_GS_PIXEL   - to / from the external grayscale unit
//   O_WR_EN, O_WR_ADDR,
//   O_WR_DATA, I_WR_READY    - sink write with valid/ready handshake
module grayscale_controller
  import grayscale_controller_pkg::*;
#(
  parameter int unsigned P_PIXEL_DEPTH    = DEF_PIXEL_DEPTH,
  parameter int unsigned P_SUBPIXEL_DEPTH = P_PIXEL_DEPTH / 3,
  parameter int unsigned P_IMG_WIDTH      = DEF_IMG_WIDTH,
  parameter int unsigned P_IMG_HEIGHT     = DEF_IMG_HEIGHT,
  parameter int unsigned P_ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned P_GS_LATENCY     = DEF_GS_LATENCY,
  parameter int unsigned P_FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic                        I_CLK,
  input  logic                        I_RESET,
  input  logic                        I_START,
  output logic                        O_BUSY,
  output logic                        O_DONE,
  output logic                        O_RD_EN,
  output logic [P_ADDR_WIDTH-1:0]     O_RD_ADDR,
  input  logic [P_PIXEL_DEPTH-1:0]    I_RD_DATA,
  output logic [P_PIXEL_DEPTH-1:0]    O_GS_PIXEL,
  input  logic [P_SUBPIXEL_DEPTH-1:0] I_GS_PIXEL,
  output logic                        O_WR_EN,
  output logic [P_ADDR_WIDTH-1:0]     O_WR_ADDR,
  output logic [P_SUBPIXEL_DEPTH-1:0] O_WR_DATA,
  input  logic                        I_WR_READY
);

  localparam int unsigned NUM_PIXELS = P_IMG_WIDTH * P_IMG_HEIGHT;
  localparam int unsigned COL_W      = clog2_min1(P_IMG_WIDTH);
  localparam int unsigned ROW_W      = clog2_min1(P_IMG_HEIGHT);
  localparam int unsigned CNT_W      = $clog2(P_FIFO_DEPTH + 1);
  localparam int unsigned SR_LEN     = P_GS_LATENCY + 1;
  localparam int unsigned IFL_W      = $clog2(SR_LEN + 1);

  gs_state_e                   state_q;
  gs_state_e                   state_d;
  logic [P_ADDR_WIDTH-1:0]     rd_addr_q;
  logic [P_ADDR_WIDTH-1:0]     wr_addr_q;
  logic [COL_W-1:0]            col_q;
  logic [ROW_W-1:0]            row_q;
  logic [SR_LEN-1:0]           vld_sr_q;
  logic [IFL_W-1:0]            in_flight;
  logic [CNT_W-1:0]            fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [P_SUBPIXEL_DEPTH-1:0] fifo_head;
  logic                        credit_ok;
  logic                        last_pos;
  logic                        last_wr_addr;
  logic                        rd_en;
  logic                        wr_fire;
  logic                        busy;
  logic                        done;

  // Pixels issued to the source/grayscale path but not yet in the buffer
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < SR_LEN; i++) begin
      in_flight = in_flight + IFL_W'(vld_sr_q[i]);
    end
  end

  // A read may only be issued if its result is guaranteed a buffer slot
  assign credit_ok    = ~fifo_full &&
                        ((32'(fifo_count) + 32'(in_flight)) < P_FIFO_DEPTH);
  assign last_pos     = (col_q == COL_W'(P_IMG_WIDTH - 1)) &&
                        (row_q == ROW_W'(P_IMG_HEIGHT - 1));
  assign wr_fire      = ~fifo_empty & I_WR_READY;
  assign last_wr_addr = (wr_addr_q == P_ADDR_WIDTH'(NUM_PIXELS - 1));

  // Next-state and state-decoded outputs
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (I_START) state_d = RUN;
      end
      RUN: begin
        busy  = 1'b1;
        rd_en = credit_ok;
        if (credit_ok && last_pos) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (wr_fire && last_wr_addr) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge I_CLK) begin
    if (I_RESET) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Read address generation; col/row track the raster position
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      rd_addr_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
    end else if (rd_en) begin
      if (last_pos) begin
        rd_addr_q <= '0;
        col_q     <= '0;
        row_q     <= '0;
      end else begin
        rd_addr_q <= rd_addr_q + P_ADDR_WIDTH'(1);
        if (col_q == COL_W'(P_IMG_WIDTH - 1)) begin
          col_q <= '0;
          row_q <= row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  // Valid tag follows each read through source and grayscale latency
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      vld_sr_q <= '0;
    end else begin
      vld_sr_q[0] <= rd_en;
      for (int i = 1; i < SR_LEN; i++) begin
        vld_sr_q[i] <= vld_sr_q[i-1];
      end
    end
  end

  // Sink address advances per accepted write, wrapping for the next frame
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      wr_addr_q <= '0;
    end else if (wr_fire) begin
      wr_addr_q <= last_wr_addr ? '0 : wr_addr_q + P_ADDR_WIDTH'(1);
    end
  end

  gs_out_fifo #(
    .P_WIDTH (P_SUBPIXEL_DEPTH),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (I_CLK),
    .reset     (I_RESET),
    .push      (vld_sr_q[SR_LEN-1]),
    .push_data (I_GS_PIXEL),
    .pop       (I_WR_READY),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign O_BUSY     = busy;
  assign O_DONE     = done;
  assign O_RD_EN    = rd_en;
  assign O_RD_ADDR  = rd_addr_q;
  assign O_GS_PIXEL = I_RD_DATA;
  assign O_WR_EN    = ~fifo_empty;
  assign O_WR_ADDR  = wr_addr_q;
  assign O_WR_DATA  = fifo_head;

endmodule

// File: tb/tb_grayscale_controller.sv
// Directed bench for grayscale_controller on a 4x2 frame with a one-cycle
// grayscale model and a one-cycle-latency source memory.
module tb_grayscale_controller;
  import grayscale_controller_pkg::*;

  localparam int unsigned PIX_W  = 24;
  localparam int unsigned GRAY_W = 8;
  localparam int unsigned IMG_W  = 4;
  localparam int unsigned IMG_H  = 2;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned GS_LAT = 1;
  localparam int unsigned FIFO_D = 4;
  localparam int          WINDOW = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data = '0;
  logic [PIX_W-1:0]  gs_out;
  logic [GRAY_W-1:0] gs_in = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [GRAY_W-1:0] wr_data;
  logic              wr_ready = 1'b0;

  logic [PIX_W-1:0]  img [8];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  grayscale_controller #(
    .P_PIXEL_DEPTH (PIX_W),
    .P_IMG_WIDTH   (IMG_W),
    .P_IMG_HEIGHT  (IMG_H),
    .P_ADDR_WIDTH  (ADDR_W),
    .P_GS_LATENCY  (GS_LAT),
    .P_FIFO_DEPTH  (FIFO_D)
  ) dut (
    .I_CLK      (clk),
    .I_RESET    (rst),
    .I_START    (start),
    .O_BUSY     (busy),
    .O_DONE     (done),
    .O_RD_EN    (rd_en),
    .O_RD_ADDR  (rd_addr),
    .I_RD_DATA  (rd_data),
    .O_GS_PIXEL (gs_out),
    .I_GS_PIXEL (gs_in),
    .O_WR_EN    (wr_en),
    .O_WR_ADDR  (wr_addr),
    .O_WR_DATA  (wr_data),
    .I_WR_READY (wr_ready)
  );

  // Luma approximation: (77R + 150G + 29B) / 256
  function automatic logic [GRAY_W-1:0] gray(input logic [PIX_W-1:0] p);
    logic [17:0] s;
    s = 18'(p[23:16]) * 18'd77 + 18'(p[15:8]) * 18'd150 + 18'(p[7:0]) * 18'd29;
    return s[15:8];
  endfunction

  // Source memory: data one cycle after the read strobe
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= img[rd_addr];
  end

  // External grayscale unit with one cycle of latency
  always_ff @(posedge clk) begin
    gs_in <= gray(gs_out);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    32'(busy),        32'd0);
    check({tag, "_done"},    32'(done),        32'd0);
    check({tag, "_rd_en"},   32'(rd_en),       32'd0);
    check({tag, "_wr_en"},   32'(wr_en),       32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr),     32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr),     32'd0);
    check({tag, "_wr_data"}, 32'(wr_data),     32'd0);
    check({tag, "_state"},   32'(dut.state_q), 32'(IDLE));
  endtask

  // rdy_mode: 0 = always ready, 1 = stall cycles 2..11, 2 = ready on even cycles
  task automatic run_frame(input string tag, input int rdy_mode, input bit hold_start);
    int                n_rd = 0;
    int                n_wr = 0;
    int                n_done = 0;
    int                first_rd = -1;
    int                first_wr = -1;
    int                last_wr = -1;
    int                max_out = 0;
    logic [ADDR_W-1:0] exp_rd = '0;
    logic [ADDR_W-1:0] exp_wr = '0;
    logic              stalled = 1'b0;
    logic [GRAY_W-1:0] held_data = '0;
    logic [ADDR_W-1:0] held_addr = '0;

    start = 1'b1;
    step();
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    if (!hold_start) start = 1'b0;

    for (int cyc = 0; cyc < WINDOW; cyc++) begin
      case (rdy_mode)
        1:       wr_ready = !(cyc >= 2 && cyc < 12);
        2:       wr_ready = (cyc % 2 == 0);
        default: wr_ready = 1'b1;
      endcase
      if (n_rd - n_wr > max_out) max_out = n_rd - n_wr;

      if (rd_en) begin
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'(exp_rd));
        check({tag, "_credit"}, 32'(n_rd - n_wr < 4), 32'd1);
        if (first_rd < 0) first_rd = cyc;
        exp_rd++;
        n_rd++;
      end

      if (wr_en) begin
        if (stalled) begin
          check({tag, "_stall_data"}, 32'(wr_data), 32'(held_data));
          check({tag, "_stall_addr"}, 32'(wr_addr), 32'(held_addr));
        end
        if (wr_ready) begin
          check({tag, "_wr_addr"}, 32'(wr_addr), 32'(exp_wr));
          check({tag, "_wr_data"}, 32'(wr_data), 32'(gray(img[exp_wr])));
          if (exp_wr == '0) check({tag, "_px0"}, 32'(wr_data), 32'h97);
          if (first_wr < 0) first_wr = cyc;
          last_wr = cyc;
          exp_wr++;
          n_wr++;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          held_data = wr_data;
          held_addr = wr_addr;
        end
      end

      if (done) begin
        n_done++;
        start = 1'b0;
      end
      step();
    end

    start = 1'b0;
    check({tag, "_n_rd"},     32'(n_rd),   32'd8);
    check({tag, "_n_wr"},     32'(n_wr),   32'd8);
    check({tag, "_n_done"},   32'(n_done), 32'd1);
    check({tag, "_busy_end"}, 32'(busy),   32'd0);
    if (rdy_mode == 0) begin
      check({tag, "_latency"}, 32'(first_wr - first_rd), 32'd3);
      check({tag, "_burst"},   32'(last_wr - first_wr),   32'd7);
    end
    if (rdy_mode == 1) check({tag, "_max_pending"}, 32'(max_out), 32'd4);
  endtask

  initial begin
    int n_rd_pre;

    img[0] = 24'hFF7F00;
    img[1] = 24'h123456;
    img[2] = 24'h000000;
    img[3] = 24'hFFFFFF;
    img[4] = 24'h804020;
    img[5] = 24'h0A0B0C;
    img[6] = 24'h00FF00;
    img[7] = 24'h7F7F7F;

    rst = 1'b1;
    repeat (3) step();
    check_idle("por");
    rst = 1'b0;
    step();
    check_idle("por_rel");

    run_frame("nom", 0, 1'b0);
    run_frame("bp", 1, 1'b0);

    // Reset in the middle of a frame, after three reads
    wr_ready = 1'b1;
    start    = 1'b1;
    step();
    start    = 1'b0;
    n_rd_pre = 0;
    for (int c = 0; c < 3; c++) begin
      if (rd_en) n_rd_pre++;
      step();
    end
    check("mid_reads", 32'(n_rd_pre), 32'd3);
    rst = 1'b1;
    step();
    check_idle("mid_rst");
    rst = 1'b0;
    repeat (4) step();
    check_idle("mid_quiet");

    run_frame("restart", 0, 1'b0);
    run_frame("hold", 0, 1'b1);
    run_frame("tgl", 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
